// File: rtl/fifo_sync_buf.sv
// rtl/fifo_sync_buf.sv - single-clock first-word-fall-through buffer with reserve threshold, flush and sticky error flags
module fifo_sync_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] reserve,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_valid,
    output logic                  wr_request,
    output logic                  full,
    input  logic                  rd_request,
    input  logic                  nap,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_util,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH+1:0] free_words;
    logic                  pop;
    logic                  wr_accept;

    // The extra pointer bit distinguishes full from empty when the low bits match.
    assign fifo_util  = wr_ptr - rd_ptr;
    assign empty      = (fifo_util == '0);
    assign full       = (fifo_util == (ADDR_WIDTH+1)'(DEPTH));
    assign free_words = (ADDR_WIDTH+2)'(DEPTH) - {1'b0, fifo_util};
    assign wr_request = (free_words > {2'b00, reserve});
    assign data_out   = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // A pop frees the slot in the same cycle, so a write into a full buffer is still accepted.
    assign pop       = rd_request & ~nap & ~empty;
    assign wr_accept = wr_valid & (~full | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_valid && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (rd_request && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Array is cleared only by reset; flush keeps the contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

endmodule

// File: doc/fifo_sync_buf.md
# fifo_sync_buf

Parametrised single-clock data buffer, successor to the dual-clock FIFO. Carries data words between the SD host command/data path and the bus-side engine in one clock domain. Adds:
- generic width and depth
- programmable reserve (almost-full) threshold
- first-word-fall-through output with non-destructive peek (nap)
- synchronous flush
- sticky overflow/underflow flags
- occupancy count

## Interface
- DATA_WIDTH, 16, data word width in bits
- ADDR_WIDTH, 3, address width; depth DEPTH = 2**ADDR_WIDTH words

- clk  in  1  sole clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers, count and error flags
- reserve  in  ADDR_WIDTH  free words withheld before wr_request drops
- data_in  in  DATA_WIDTH  write data
- wr_valid  in  1  write strobe, one word per cycle
- wr_request  out  1  buffer has more than reserve free words
- full  out  1  fifo_util == DEPTH
- rd_request  in  1  read strobe
- nap  in  1  with rd_request: read without advancing the read pointer
- data_out  out  DATA_WIDTH  head word, valid whenever empty == 0
- empty  out  1  fifo_util == 0
- fifo_util  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- **Storage:** register array of DEPTH x DATA_WIDTH.
- **Pointers:** wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the array. Pointers wrap modulo 2*DEPTH.
- **Occupancy:** fifo_util = wr_ptr - rd_ptr, computed modulo 2**(ADDR_WIDTH+1).
- **Write accepted:** wr_valid=1 and (full=0, or a pop occurs in the same cycle). Effect: mem[wr_ptr] <= data_in, wr_ptr += 1.
- **Write refused:** wr_valid=1, full=1 and no pop. The word is dropped, wr_ptr is unchanged, and overflow <= 1.
- **Pop:** rd_request=1, nap=0, empty=0. Effect: rd_ptr += 1.
- **Peek:** rd_request=1, nap=1, empty=0. No state change; data_out still shows the head.
- **Read while empty:** rd_request=1 and empty=1, for any nap value. No pointer change, underflow <= 1. A simultaneous write is still accepted.
- **Simultaneous pop and write:** fifo_util is unchanged, including when full.
- **wr_request:** combinational, wr_request = (DEPTH - fifo_util) > reserve, compared at ADDR_WIDTH+2 bits. wr_request is advisory; a writer that ignores it is bounded only by full and overflow.
- **data_out:** combinational, data_out = mem[rd_ptr[ADDR_WIDTH-1:0]]. It is first-word-fall-through and has no read latency.
- **flush:** highest priority among synchronous operations. It zeroes wr_ptr, rd_ptr, overflow and underflow, and ignores wr_valid and rd_request in that cycle. Array contents are retained.
- **Error flags:** overflow and underflow clear only on flush or reset.

## Timing
- **Reset values (while reset_n=0):**
  - pointers 0, array all zeros
  - data_out 0, empty 1, full 0, fifo_util 0
  - wr_request 1 (reserve <= DEPTH-1 always)
  - overflow 0, underflow 0
- **Reset release:** state is held until the first rising clk edge with reset_n=1.
- **Write-to-read latency:** a word written at edge N raises the count at edge N. empty falls and data_out shows that word after edge N, so it can be popped at edge N+1.
- **Pop latency:** a pop at edge N presents the next head on data_out after edge N; empty rises after edge N if the popped word was the last.
- **Flag settling:** full, empty, fifo_util and wr_request are valid one clock-to-q after each edge. They have no extra pipeline stage.
- **reserve changes:** take effect on wr_request combinationally.
- **Reset mid-operation:** asserting reset_n=0 at any time forces all reset values immediately. Words in flight are discarded.

## Test plan
Parameters for all scenarios: DATA_WIDTH=16, ADDR_WIDTH=3.
1. Reset, then write 0x0001..0x0008 on 8 consecutive cycles -> fifo_util=8, full=1, wr_request=0. A 9th write (0x0009) sets overflow=1 and fifo_util stays 8.
2. From full, pop 8 words on consecutive cycles -> data_out reads 0x0001..0x0008 in order, empty=1 after the 8th pop. A further rd_request sets underflow=1.
3. reserve=2 -> wr_request=1 at fifo_util 0..5 and 0 at fifo_util 6..8. Changing reserve to 0 with fifo_util=6 raises wr_request=1 in the same cycle.
4. Load 0x00AA, 0x00BB. Assert rd_request with nap=1 for 3 cycles -> data_out stays 0x00AA and fifo_util stays 2. Then nap=0 for one cycle -> data_out=0x00BB, fifo_util=1.
5. Wrap and simultaneous traffic:
   - Fill to 8, then wr_valid and rd_request together for 20 cycles with an incrementing data pattern.
   - Required: fifo_util stays 8, no overflow, and output order is contiguous across pointer wrap.
   - Then, from empty, assert wr_valid and rd_request together -> write accepted, underflow=1, fifo_util=1.
6. With fifo_util=5 and overflow=1, assert flush with wr_valid=1 -> next cycle fifo_util=0, empty=1, overflow=0. Assert reset_n=0 mid-burst -> all outputs return to reset values without waiting for a clock edge.
